// File: rtl/pn9_dewhiten_pkg.sv
// Shared types and constants for the PN9 dewhitening receive deframer and the
// pn9_lfsr block it shares with the transmit whitener.
package pn9_dewhiten_pkg;

  typedef enum logic [1:0] {
    BT_NONE    = 2'd0,
    BT_PHR     = 2'd1,
    BT_PAYLOAD = 2'd2,
    BT_FCS     = 2'd3
  } byte_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PHR,
    ST_PSDU,
    ST_DONE
  } rx_state_t;

  // PHR byte0 fields; bits 2:1 are reserved and never stored
  localparam int unsigned PHR_MS_BIT     = 0;
  localparam int unsigned PHR_FCS_BIT    = 3;
  localparam int unsigned PHR_DW_BIT     = 4;
  localparam int unsigned PHR_LEN_HI_LSB = 5;

  typedef struct packed {
    logic [2:0] len_hi;
    logic       dw;
    logic       fcs2;
    logic       ms;
  } phr0_t;

  // x^9 + x^5 + 1: output s[0], feed s[0]^s[5] into s[8]
  localparam int unsigned PN9_TAP_OUT = 0;
  localparam int unsigned PN9_TAP_FB  = 5;

  localparam logic [15:0] CRC16_POLY    = 16'h8408;
  localparam logic [15:0] CRC16_INIT    = '0;
  localparam logic [15:0] CRC16_RESIDUE = '0;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = '1;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ CRC16_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ CRC32_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pn9_lfsr.sv
// PN9 whitening sequence generator: W output bits per enabled cycle, bit 0 first.
// Registered 9-bit state with synchronous load of SEED.
module pn9_lfsr
  import pn9_dewhiten_pkg::*;
#(
  parameter int unsigned W    = 1,
  parameter logic [8:0]  SEED = 9'h1FF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] mask
);

  logic [8:0] state;
  logic [8:0] adv;

  always_comb begin
    adv  = state;
    mask = '0;
    for (int unsigned i = 0; i < W; i++) begin
      mask[i] = adv[PN9_TAP_OUT];
      adv     = {adv[PN9_TAP_OUT] ^ adv[PN9_TAP_FB], adv[8:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    state <= SEED;
    else if (load) state <= SEED;
    else if (en)   state <= adv;
  end

endmodule

// File: rtl/pn9_dewhiten_deframer.sv
// SUN-FSK receive deframer: parses the 2-octet PHR, PN9-dewhitens the PSDU and
// emits tagged bytes. Define DEWHITEN_CRC_EN to add FCS checking and crc_ok.
module pn9_dewhiten_deframer
  import pn9_dewhiten_pkg::*;
#(
  parameter int unsigned IN_W     = 1,
  parameter int unsigned MAX_LEN  = 2047,
  parameter logic [8:0]  PN9_SEED = 9'h1FF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] data_in,
  input  logic            data_in_valid,
  output logic [7:0]      data_out,
  output logic            data_out_valid,
  output logic [1:0]      data_out_type,
  output logic            frame_end,
  output logic            phr_err,
  output logic            frame_abort,
  output logic [10:0]     rx_len,
  output logic            rx_fcs2,
  output logic            rx_dw
`ifdef DEWHITEN_CRC_EN
  ,
  output logic            crc_ok
`endif
);

  localparam int unsigned BEATS     = 8 / IN_W;
  localparam logic [2:0]  LAST_BEAT = 3'(BEATS - 1);
  localparam logic [11:0] MAX_LEN_W = 12'(MAX_LEN);

  rx_state_t  state, state_n;
  logic [2:0] beat_cnt, beat_cnt_n;
  logic [7:0] byte_acc, byte_acc_n;
  phr0_t      phr0, phr0_n;
  logic       phr_hi, phr_hi_n;
  logic [10:0] rem_cnt, rem_n;
  logic [10:0] rx_len_n;
  logic        rx_fcs2_n, rx_dw_n;
  logic [7:0]  dout_n;
  logic        dv_n, fe_n, perr_n, abort_n;
  byte_type_t  type_n, out_type;

  logic [IN_W-1:0] pn_mask, beat_bits;
  logic [7:0]      assembled;
  logic            byte_done, lfsr_load, lfsr_en;
  logic [10:0]     len_dec, fcs_len_dec, fcs_len_cur;
  logic            phr_bad;

  pn9_lfsr #(
    .W    (IN_W),
    .SEED (PN9_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .en    (lfsr_en),
    .mask  (pn_mask)
  );

  // Byte assembly and PHR decode of the byte completing on this beat
  always_comb begin
    beat_bits = data_in;
    if (state == ST_PSDU && rx_dw) beat_bits = data_in ^ pn_mask;
    assembled = byte_acc;
    assembled[32'(beat_cnt) * IN_W +: IN_W] = beat_bits;
    byte_done   = (beat_cnt == LAST_BEAT);
    len_dec     = {phr0.len_hi, assembled};
    fcs_len_dec = phr0.fcs2 ? 11'd2 : 11'd4;
    fcs_len_cur = rx_fcs2 ? 11'd2 : 11'd4;
    phr_bad     = phr0.ms || ({1'b0, len_dec} > MAX_LEN_W) || (len_dec < fcs_len_dec);
  end

  always_comb begin
    state_n    = state;
    beat_cnt_n = beat_cnt;
    byte_acc_n = byte_acc;
    phr0_n     = phr0;
    phr_hi_n   = phr_hi;
    rem_n      = rem_cnt;
    rx_len_n   = rx_len;
    rx_fcs2_n  = rx_fcs2;
    rx_dw_n    = rx_dw;
    dout_n     = '0;
    dv_n       = 1'b0;
    type_n     = BT_NONE;
    fe_n       = 1'b0;
    perr_n     = 1'b0;
    abort_n    = 1'b0;
    lfsr_load  = 1'b0;
    lfsr_en    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (data_in_valid) begin
          state_n   = ST_PHR;
          lfsr_load = 1'b1;
        end
      end
      ST_PHR, ST_PSDU: begin
        if (!data_in_valid) begin
          state_n    = ST_IDLE;
          abort_n    = 1'b1;
          beat_cnt_n = '0;
          byte_acc_n = '0;
          phr_hi_n   = 1'b0;
        end
      end
      ST_DONE: begin
        if (!data_in_valid) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    // The first valid beat in IDLE is already PHR data; DONE ignores beats
    if (data_in_valid && state != ST_DONE) begin
      beat_cnt_n = beat_cnt + 3'd1;
      byte_acc_n = assembled;
      lfsr_en    = (state == ST_PSDU);
      if (byte_done) begin
        beat_cnt_n = '0;
        byte_acc_n = '0;
        dv_n       = 1'b1;
        dout_n     = assembled;
        if (state == ST_PSDU) begin
          if (rem_cnt > fcs_len_cur) type_n = BT_PAYLOAD;
          else                       type_n = BT_FCS;
          rem_n = rem_cnt - 11'd1;
          if (rem_cnt == 11'd1) begin
            fe_n    = 1'b1;
            state_n = ST_DONE;
          end
        end else if (!phr_hi) begin
          type_n        = BT_PHR;
          phr_hi_n      = 1'b1;
          phr0_n.ms     = assembled[PHR_MS_BIT];
          phr0_n.fcs2   = assembled[PHR_FCS_BIT];
          phr0_n.dw     = assembled[PHR_DW_BIT];
          phr0_n.len_hi = assembled[PHR_LEN_HI_LSB +: 3];
        end else begin
          type_n    = BT_PHR;
          phr_hi_n  = 1'b0;
          rx_len_n  = len_dec;
          rx_fcs2_n = phr0.fcs2;
          rx_dw_n   = phr0.dw;
          rem_n     = len_dec;
          perr_n    = phr_bad;
          state_n   = phr_bad ? ST_DONE : ST_PSDU;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      beat_cnt       <= '0;
      byte_acc       <= '0;
      phr0           <= '0;
      phr_hi         <= 1'b0;
      rem_cnt        <= '0;
      rx_len         <= '0;
      rx_fcs2        <= 1'b0;
      rx_dw          <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      out_type       <= BT_NONE;
      frame_end      <= 1'b0;
      phr_err        <= 1'b0;
      frame_abort    <= 1'b0;
    end else begin
      state          <= state_n;
      beat_cnt       <= beat_cnt_n;
      byte_acc       <= byte_acc_n;
      phr0           <= phr0_n;
      phr_hi         <= phr_hi_n;
      rem_cnt        <= rem_n;
      rx_len         <= rx_len_n;
      rx_fcs2        <= rx_fcs2_n;
      rx_dw          <= rx_dw_n;
      data_out       <= dout_n;
      data_out_valid <= dv_n;
      out_type       <= type_n;
      frame_end      <= fe_n;
      phr_err        <= perr_n;
      frame_abort    <= abort_n;
    end
  end

  assign data_out_type = out_type;

`ifdef DEWHITEN_CRC_EN
  logic [15:0] crc16_q, crc16_n;
  logic [31:0] crc32_q, crc32_n;
  logic        crc_ok_n;

  // Both CRCs run on every PSDU byte; rx_fcs2 picks the one judged at the end
  always_comb begin
    crc16_n  = crc16_q;
    crc32_n  = crc32_q;
    crc_ok_n = 1'b0;
    if (lfsr_load) begin
      crc16_n = CRC16_INIT;
      crc32_n = CRC32_INIT;
    end else if (state == ST_PSDU && data_in_valid && byte_done) begin
      crc16_n = crc16_byte(crc16_q, assembled);
      crc32_n = crc32_byte(crc32_q, assembled);
      if (rem_cnt == 11'd1)
        crc_ok_n = rx_fcs2 ? (crc16_n == CRC16_RESIDUE) : (crc32_n == CRC32_RESIDUE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc16_q <= CRC16_INIT;
      crc32_q <= CRC32_INIT;
      crc_ok  <= 1'b0;
    end else begin
      crc16_q <= crc16_n;
      crc32_q <= crc32_n;
      crc_ok  <= crc_ok_n;
    end
  end
`endif

endmodule

// File: tb/tb_pn9_dewhiten_deframer.sv
// Bench for pn9_dewhiten_deframer: IN_W=1 and IN_W=8 instances driven with
// randomized frames and checked against a byte-level frame model.
module tb_pn9_dewhiten_deframer;

  localparam int unsigned MAX_LEN = 40;
  localparam int unsigned PN_BITS = 8 * (MAX_LEN + 8);

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] t;
    logic       fe;
    logic       pe;
    logic       crc;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [0:0]  din1 = '0;
  logic [7:0]  din8 = '0;
  logic        vld[2];
  logic [7:0]  dout[2];
  logic [1:0]  dtype[2];
  logic        dvalid[2], fend[2], perr[2], abrt[2], fcs2o[2], dwo[2], crcok[2];
  logic [10:0] rxlen[2];

  int total = 0;
  int bad = 0;
  int abort_cnt[2];
  int exp_abort[2];
  rec_t expq0[$];
  rec_t expq1[$];
  bit pn[PN_BITS];

  pn9_dewhiten_deframer #(.IN_W(1), .MAX_LEN(MAX_LEN), .PN9_SEED(9'h1FF)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_in(din1), .data_in_valid(vld[0]),
    .data_out(dout[0]), .data_out_valid(dvalid[0]), .data_out_type(dtype[0]),
    .frame_end(fend[0]), .phr_err(perr[0]), .frame_abort(abrt[0]),
    .rx_len(rxlen[0]), .rx_fcs2(fcs2o[0]), .rx_dw(dwo[0])
`ifdef DEWHITEN_CRC_EN
    , .crc_ok(crcok[0])
`endif
  );

  pn9_dewhiten_deframer #(.IN_W(8), .MAX_LEN(MAX_LEN), .PN9_SEED(9'h1FF)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .data_in(din8), .data_in_valid(vld[1]),
    .data_out(dout[1]), .data_out_valid(dvalid[1]), .data_out_type(dtype[1]),
    .frame_end(fend[1]), .phr_err(perr[1]), .frame_abort(abrt[1]),
    .rx_len(rxlen[1]), .rx_fcs2(fcs2o[1]), .rx_dw(dwo[1])
`ifdef DEWHITEN_CRC_EN
    , .crc_ok(crcok[1])
`endif
  );

`ifndef DEWHITEN_CRC_EN
  assign crcok[0] = 1'b0;
  assign crcok[1] = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [7:0] pn_byte(input int k);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = pn[8 * k + b];
    return r;
  endfunction

`ifdef DEWHITEN_CRC_EN
  function automatic logic [31:0] ref_fcs(input logic [7:0] q[$], input bit is16);
    logic [31:0] c, poly;
    c    = is16 ? 32'h0 : 32'hFFFF_FFFF;
    poly = is16 ? 32'h0000_8408 : 32'hEDB8_8320;
    foreach (q[i])
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ q[i][b]) c = (c >> 1) ^ poly;
        else                c = c >> 1;
      end
    return is16 ? c : ~c;
  endfunction
`endif

  task automatic push(input int k, input rec_t r);
    if (k == 0) expq0.push_back(r);
    else        expq1.push_back(r);
  endtask

  task automatic mon(input int k);
    rec_t got, want;
    int   n;
    got = '{dout[k], dtype[k], fend[k], perr[k], crcok[k]};
    if (abrt[k]) abort_cnt[k]++;
    n = (k == 0) ? expq0.size() : expq1.size();
    if (dvalid[k]) begin
      if (n == 0) check("byte_unexpected", 32'(dvalid[k]), 32'd0);
      else begin
        want = (k == 0) ? expq0.pop_front() : expq1.pop_front();
        check("byte", 32'(got), 32'(want));
      end
    end else begin
      check("quiet", 32'(got), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  task automatic drive_byte(input int k, input logic [7:0] b, input int nbeats);
    if (k == 0) begin
      for (int i = 0; i < nbeats; i++) begin
        @(negedge clk);
        din1   = b[i];
        vld[0] = 1'b1;
      end
    end else if (nbeats > 0) begin
      @(negedge clk);
      din8   = b;
      vld[1] = 1'b1;
    end
  endtask

  task automatic drop(input int k);
    @(negedge clk);
    vld[k] = 1'b0;
    if (k == 0) din1 = '0;
    else        din8 = '0;
  endtask

  // abort_at < 0: complete frame; otherwise stop after abort_at PSDU bytes plus a partial byte
  task automatic run_frame(input int k, input bit ms, input bit fcs2, input bit dw,
                           input int len, input int abort_at, input bit flip);
    logic [7:0]  b0, b1, line;
    logic [7:0]  plain[$];
    logic [10:0] l11;
    logic [31:0] fcs_val;
    int          fcs_len, full, n_send, part;
    bit          phr_bad, is_fcs, crc_exp;
    full    = (k == 0) ? 8 : 1;
    l11     = 11'(len);
    fcs_len = fcs2 ? 2 : 4;
    phr_bad = ms || (len > int'(MAX_LEN)) || (len < fcs_len);
    b0 = {l11[10:8], dw, fcs2, 2'($urandom), ms};
    b1 = l11[7:0];
    push(k, '{b0, 2'd1, 1'b0, 1'b0, 1'b0});
    push(k, '{b1, 2'd1, 1'b0, phr_bad, 1'b0});
    drive_byte(k, b0, full);
    drive_byte(k, b1, full);
    if (phr_bad) begin
      repeat (3) drive_byte(k, 8'($urandom), full);
      drop(k);
    end else begin
      for (int i = 0; i < len - fcs_len; i++) plain.push_back(8'($urandom));
      fcs_val = $urandom;
`ifdef DEWHITEN_CRC_EN
      fcs_val = ref_fcs(plain, fcs2);
`endif
      for (int j = 0; j < fcs_len; j++) plain.push_back(fcs_val[8 * j +: 8]);
      if (flip) plain[0][0] = ~plain[0][0];
      n_send = (abort_at >= 0) ? abort_at : len;
      for (int i = 0; i < n_send; i++) begin
        line    = dw ? (plain[i] ^ pn_byte(i)) : plain[i];
        is_fcs  = (i >= len - fcs_len);
        crc_exp = 1'b0;
`ifdef DEWHITEN_CRC_EN
        crc_exp = (i == len - 1) && !flip;
`endif
        push(k, '{plain[i], is_fcs ? 2'd3 : 2'd2, 1'(i == len - 1), 1'b0, crc_exp});
        drive_byte(k, line, full);
      end
      if (abort_at >= 0) begin
        part = (k == 0) ? $urandom_range(0, 7) : 0;
        drive_byte(k, 8'($urandom), part);
        drop(k);
        exp_abort[k]++;
        @(negedge clk);
        check("abort_pulse", 32'(abrt[k]), 32'd1);
      end else begin
        drop(k);
      end
    end
    repeat (3) @(negedge clk);
    check("bytes_left", (k == 0) ? expq0.size() : expq1.size(), 32'd0);
    check("rx_len", 32'(rxlen[k]), 32'(l11));
    check("rx_fcs2", 32'(fcs2o[k]), 32'(fcs2));
    check("rx_dw", 32'(dwo[k]), 32'(dw));
    check("abort_count", abort_cnt[k], exp_abort[k]);
  endtask

  initial begin
    int k, fl, len;
    bit f2, dw;
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    abort_cnt[0] = 0; abort_cnt[1] = 0;
    exp_abort[0] = 0; exp_abort[1] = 0;
    // PN9 from seed 1FF: x[n+9] = x[n] ^ x[n+5]
    for (int i = 0; i < 9; i++) pn[i] = 1'b1;
    for (int i = 9; i < int'(PN_BITS); i++) pn[i] = pn[i - 9] ^ pn[i - 4];

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      check("reset_outputs",
            32'({dout[i], dtype[i], dvalid[i], fend[i], perr[i], abrt[i],
                 rxlen[i], fcs2o[i], dwo[i], crcok[i]}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(0, 0, 0, 1, 4, -1, 0);
    run_frame(1, 0, 1, 0, 5, -1, 0);
    run_frame(0, 1, 0, 0, 16, -1, 0);
    run_frame(1, 1, 0, 0, 16, -1, 0);
    run_frame(1, 0, 0, 0, 3, -1, 0);
    run_frame(1, 0, 1, 0, MAX_LEN + 1, -1, 0);
    run_frame(1, 0, 1, 1, MAX_LEN, -1, 0);
    run_frame(0, 0, 1, 1, 2, -1, 0);
    run_frame(0, 0, 0, 1, 10, 2, 0);
    run_frame(0, 0, 0, 1, 8, -1, 0);
    run_frame(1, 0, 0, 1, 10, 2, 0);
    run_frame(1, 0, 0, 1, 9, -1, 0);
`ifdef DEWHITEN_CRC_EN
    run_frame(0, 0, 1, 1, 8, -1, 0);
    run_frame(0, 0, 1, 1, 8, -1, 1);
    run_frame(1, 0, 0, 1, 9, -1, 0);
    run_frame(1, 0, 0, 1, 9, -1, 1);
`endif

    for (int n = 0; n < 14; n++) begin
      k  = $urandom_range(0, 1);
      f2 = 1'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      fl = f2 ? 2 : 4;
      case ($urandom_range(0, 4))
        0, 1: run_frame(k, 0, f2, dw, $urandom_range(fl, MAX_LEN), -1, 0);
        2:    run_frame(k, 1, f2, dw, $urandom_range(fl, MAX_LEN), -1, 0);
        3: begin
          len = ($urandom_range(0, 1) == 1) ? $urandom_range(0, fl - 1)
                                            : $urandom_range(MAX_LEN + 1, 2047);
          run_frame(k, 0, f2, dw, len, -1, 0);
        end
        default: begin
          len = $urandom_range(fl + 1, MAX_LEN);
          run_frame(k, 0, f2, dw, len, $urandom_range(0, len - 1), 0);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
